rational_resampler: RTL and testbench

- Generic L/M polyphase fractional resampler; successor to the fixed 2/3 decimator in the DFE chain.
- Interpolation by L and decimation by M are set by parameters.
- Uses one time-multiplexed MAC, so multiplier count does not grow with tap count.
- Adds valid/ready handshakes on both sides, runtime coefficient loading and registered bypass; sits between the CIC/halfband stages and the channel filter.

---
 rtl/dfe_pkg.sv | 29 ++
 rtl/resamp_coef_ram.sv | 23 ++
 rtl/rational_resampler.sv | 166 ++++++++++++++++
 tb/tb_rational_resampler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfe_pkg.sv
// Shared definitions for the DFE resampler: state encoding, clog2 helper, saturation.
package dfe_pkg;

    typedef enum logic [1:0] {
        ST_NEED = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } rs_state_e;

    function automatic int dfe_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Clamp a signed value into the range of a width-bit signed number.
    function automatic logic signed [63:0] dfe_saturate(input logic signed [63:0] value,
                                                        input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) return max_v;
        if (value < min_v) return min_v;
        return value;
    endfunction

endpackage

// File: rtl/resamp_coef_ram.sv
// Coefficient store: one write port, one registered read port, no reset on the array.
module resamp_coef_ram #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             CLK,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read samples the array before this edge's write lands: write-after-read.
    always_ff @(posedge CLK) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/rational_resampler.sv
// L/M polyphase resampler with one time-multiplexed MAC and a registered bypass path.
// Optional ROUND_SAT_EN: round half up and saturate the output instead of shift and wrap.
module rational_resampler
    import dfe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int FRAC_WIDTH = 15,
    parameter int L          = 2,
    parameter int M          = 3,
    parameter int TAPS_NUM   = 138
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        bypass,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        coef_we,
    input  logic [$clog2(TAPS_NUM)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]       coef_wdata,
    output logic                        busy
);

    localparam int K         = TAPS_NUM / L;
    localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + dfe_clog2(K);
    localparam int AW        = $clog2(TAPS_NUM);
    localparam int CNT_W     = dfe_clog2(K + 1);
    localparam int SW        = dfe_clog2(L + M + 1);

    // A beat moves on a rising CLK where valid and ready are both high; a raised
    // valid and its data stay put until that edge.
    rs_state_e                              state_q, state_d;
    logic [SW-1:0]                          need_q, need_d;
    logic [SW-1:0]                          phase_q, phase_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]            acc_q, acc_nxt;
    logic signed [DATA_WIDTH-1:0]           hist_q [K];
    logic [DATA_WIDTH-1:0]                  out_data_q, out_data_d;
    logic                                   out_valid_q, out_valid_d;
    logic                                   shift_en;
    logic [AW-1:0]                          rd_addr;
    logic [COEF_WIDTH-1:0]                  coef_rdata;
    logic signed [DATA_WIDTH-1:0]           tap_x;
    logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]                  result;
    int                                     phase_sum;

    resamp_coef_ram #(.DEPTH(TAPS_NUM), .WIDTH(COEF_WIDTH), .AW(AW)) u_coef_ram (
        .CLK     (CLK),
        .we_i    (coef_we),
        .waddr_i (coef_addr),
        .wdata_i (coef_wdata),
        .raddr_i (rd_addr),
        .rdata_o (coef_rdata)
    );

    // Count c issues the address of tap c; its coefficient returns at count c+1.
    assign rd_addr = (int'(cnt_q) < K) ? AW'(int'(phase_q) + int'(cnt_q) * L) : '0;

    always_comb begin
        tap_x = '0;
        for (int i = 0; i < K; i++)
            if (int'(cnt_q) == i + 1) tap_x = hist_q[i];
    end

    assign prod    = $signed(tap_x) * $signed(coef_rdata);
    assign acc_nxt = (cnt_q == '0) ? '0 : acc_q + ACC_WIDTH'(prod);

`ifdef ROUND_SAT_EN
    localparam logic signed [ACC_WIDTH:0] RND = ((ACC_WIDTH + 1)'(1) << FRAC_WIDTH) >>> 1;
    logic signed [ACC_WIDTH:0] acc_wide;

    always_comb begin
        acc_wide = $signed({acc_nxt[ACC_WIDTH-1], acc_nxt}) + RND;
        result   = DATA_WIDTH'(dfe_saturate(64'(acc_wide >>> FRAC_WIDTH), DATA_WIDTH));
    end
`else
    assign result = DATA_WIDTH'(acc_nxt >>> FRAC_WIDTH);
`endif

    always_comb begin
        state_d     = state_q;
        need_d      = need_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        shift_en    = 1'b0;
        in_ready    = 1'b0;
        phase_sum   = int'(phase_q) + M;
        case (state_q)
            ST_NEED: begin
                if (bypass) begin
                    in_ready = !out_valid_q || out_ready;
                    if (in_valid && (!out_valid_q || out_ready)) begin
                        out_data_d  = in_data;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        shift_en = 1'b1;
                        need_d   = need_q - SW'(1);
                        if (need_q <= SW'(1)) begin
                            state_d = ST_MAC;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            ST_MAC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (int'(cnt_q) == K) begin
                    state_d     = ST_OUT;
                    out_data_d  = result;
                    out_valid_d = 1'b1;
                end
            end
            ST_OUT: begin
                out_valid_d = !out_ready;
                if (out_ready) begin
                    // Whole L-steps crossed by phase+M are the inputs still owed.
                    need_d  = SW'(phase_sum / L);
                    phase_d = SW'(phase_sum % L);
                    cnt_d   = '0;
                    state_d = (phase_sum / L > 0) ? ST_NEED : ST_MAC;
                end
            end
            default: state_d = ST_NEED;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_NEED;
            need_q      <= SW'(1);
            phase_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < K; i++) hist_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            need_q      <= need_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            if (state_q == ST_MAC) acc_q <= acc_nxt;
            if (shift_en) begin
                hist_q[0] <= in_data;
                for (int i = 1; i < K; i++) hist_q[i] <= hist_q[i-1];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = !(state_q == ST_NEED && need_q == SW'(1) && !out_valid_q);

endmodule

// File: tb/tb_rational_resampler.sv
// Bench for rational_resampler: L=2, M=3, six taps, plus an 8-bit instance for wrap/saturation.
module tb_rational_resampler;

    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int FW  = 0;
    localparam int LL  = 2;
    localparam int MM  = 3;
    localparam int TN  = 6;
    localparam int KK  = TN / LL;
    localparam int AW  = 3;
    localparam int DW8 = 8;

    logic          clk;
    logic          RST;
    logic          bypass, in_valid, in_ready, out_valid, out_ready, coef_we, busy;
    logic [DW-1:0] in_data, out_data;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_wdata;
    logic           in_valid8, in_ready8, out_valid8, coef_we8, busy8;
    logic [DW8-1:0] in_data8, out_data8;
    logic [AW-1:0]  coef_addr8;
    logic [CW-1:0]  coef_wdata8;

    rational_resampler #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .FRAC_WIDTH(FW),
                         .L(LL), .M(MM), .TAPS_NUM(TN)) u_dut (
        .CLK(clk), .RST(RST), .bypass(bypass), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy)
    );

    rational_resampler #(.DATA_WIDTH(DW8), .COEF_WIDTH(CW), .FRAC_WIDTH(FW),
                         .L(LL), .M(MM), .TAPS_NUM(TN)) u_dut8 (
        .CLK(clk), .RST(RST), .bypass(1'b0), .in_data(in_data8), .in_valid(in_valid8),
        .in_ready(in_ready8), .out_data(out_data8), .out_valid(out_valid8), .out_ready(1'b1),
        .coef_we(coef_we8), .coef_addr(coef_addr8), .coef_wdata(coef_wdata8), .busy(busy8)
    );

    typedef struct {
        logic signed [DW-1:0] x;
        bit                   has_y;
        logic signed [DW-1:0] y;
    } vec_t;

    vec_t                 tbl [12];
    logic signed [DW-1:0] exp_q [$];
    logic signed [DW-1:0] exp8_q [$];
    int                   xs [$];
    int                   h_m [TN];
    int                   checks, errors;
    bit                   in_acc, in_acc8, rand_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One cycle: observe at the falling edge, then drive just after the rising edge.
    task automatic tick();
        @(negedge clk);
        in_acc  = in_valid && in_ready;
        in_acc8 = in_valid8 && in_ready8;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0d, no output expected", $signed(out_data));
            end else check("out_data", $signed(out_data), exp_q.pop_front());
        end
        if (out_valid8) begin
            if (exp8_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out8: got %0d, no output expected", $signed(out_data8));
            end else check("out_data8", $signed(out_data8), exp8_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input int x, input bit to8);
        int t;
        if (to8) begin
            in_data8  = DW8'(x);
            in_valid8 = 1'b1;
        end else begin
            in_data  = DW'(x);
            in_valid = 1'b1;
        end
        t = 0;
        do begin
            tick();
            t++;
        end while (!(to8 ? in_acc8 : in_acc) && t < 200);
        check(to8 ? "send8_accept" : "send_accept", longint'(to8 ? in_acc8 : in_acc), 1);
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input int val, input bit to8);
        if (to8) begin
            coef_we8 = 1'b1; coef_addr8 = AW'(addr); coef_wdata8 = CW'(val);
        end else begin
            coef_we = 1'b1; coef_addr = AW'(addr); coef_wdata = CW'(val);
        end
        tick();
        coef_we  = 1'b0;
        coef_we8 = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0) && t < 2000) begin
            tick();
            t++;
        end
        check("drain_left", exp_q.size() + exp8_q.size(), 0);
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        xs.delete();
    endtask

    function automatic longint fmt(input longint acc, input int w);
        longint v;
`ifdef ROUND_SAT_EN
        longint mx;
        v  = (acc + ((longint'(1) << FW) >>> 1)) >>> FW;
        mx = (longint'(1) << (w - 1)) - 1;
        if (v > mx) v = mx;
        if (v < -mx - 1) v = -mx - 1;
`else
        v = (acc >>> FW) & ((longint'(1) << w) - 1);
        if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
`endif
        return v;
    endfunction

    // Output m: phase (m*M) mod L, newest input floor(m*M/L), y = sum h[p+kL]*x[n-k].
    function automatic longint model_y(input int m);
        int     n, p;
        longint acc;
        n   = (m * MM) / LL;
        p   = (m * MM) % LL;
        acc = 0;
        for (int k = 0; k < KK; k++)
            if (n - k >= 0) acc += longint'(h_m[p + k * LL]) * longint'(xs[n - k]);
        return fmt(acc, DW);
    endfunction

    initial begin
        int lat;
        int n_rand;
        checks    = 0;
        errors    = 0;
        rand_rdy  = 1'b0;
        RST       = 1'b0;
        bypass    = 1'b0;
        in_data   = '0; in_valid  = 1'b0; out_ready = 1'b1;
        coef_we   = 1'b0; coef_addr = '0; coef_wdata = '0;
        in_data8  = '0; in_valid8 = 1'b0;
        coef_we8  = 1'b0; coef_addr8 = '0; coef_wdata8 = '0;

        tbl[0]  = '{16'sd1, 1'b1, 16'sd1};
        tbl[1]  = '{16'sd0, 1'b1, 16'sd4};
        tbl[2]  = '{16'sd0, 1'b0, 16'sd0};
        tbl[3]  = '{16'sd0, 1'b1, 16'sd0};
        tbl[4]  = '{16'sd0, 1'b1, 16'sd0};
        tbl[5]  = '{16'sd0, 1'b0, 16'sd0};
        tbl[6]  = '{16'sd1, 1'b1, 16'sd1};
        tbl[7]  = '{16'sd1, 1'b1, 16'sd6};
        tbl[8]  = '{16'sd1, 1'b0, 16'sd0};
        tbl[9]  = '{16'sd1, 1'b1, 16'sd9};
        tbl[10] = '{16'sd1, 1'b1, 16'sd12};
        tbl[11] = '{16'sd1, 1'b0, 16'sd0};

        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid8", out_valid8, 0);
        tick();
        RST = 1'b1;

        for (int i = 0; i < TN; i++) wr_coef(i, i + 1, 1'b0);
        for (int i = 0; i < TN; i++) wr_coef(i, 100, 1'b1);

        // 8-bit instance: constant 127 through h=100 overflows the output width.
`ifdef ROUND_SAT_EN
        for (int i = 0; i < 4; i++) exp8_q.push_back(8'sd127);
`else
        exp8_q.push_back(-8'sd100);
        exp8_q.push_back(8'sd56);
        exp8_q.push_back(-8'sd44);
        exp8_q.push_back(-8'sd44);
`endif
        for (int i = 0; i < 5; i++) send(127, 1'b1);
        wait_drain();

        // Impulse then DC from reset.
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].has_y) exp_q.push_back(tbl[i].y);
            send(tbl[i].x, 1'b0);
        end
        wait_drain();

        // Backpressure on output m=8 (expected 9), latency from accept to out_valid.
        out_ready = 1'b0;
        send(1, 1'b0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("latency", lat, KK + 1);
        in_valid = 1'b1;
        in_data  = 16'd1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_data", $signed(out_data), 9);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        exp_q.push_back(16'sd9);
        out_ready = 1'b1;
        wait_drain();
        exp_q.push_back(16'sd12);
        send(1, 1'b0);
        wait_drain();

        // Bypass: each accepted sample appears registered one edge later.
        bypass = 1'b1;
        tick();
        foreach (tbl[i]) begin
            int bv;
            if (i >= 3) break;
            bv = (i == 0) ? 100 : (i == 1) ? -5 : 7;
            exp_q.push_back(DW'(bv));
            send(bv, 1'b0);
            check("byp_valid", out_valid, 1);
            check("byp_data", $signed(out_data), bv);
        end
        wait_drain();
        bypass = 1'b0;
        send(1, 1'b0);
        exp_q.push_back(16'sd9);
        send(1, 1'b0);
        exp_q.push_back(16'sd12);
        send(1, 1'b0);
        wait_drain();

        // Idle rewrite of h[3], reset in the middle of MAC, then a fresh impulse.
        apply_reset();
        wr_coef(3, 10, 1'b0);
        send(1, 1'b0);
        tick();
        tick();
        check("mac_busy", busy, 1);
        RST = 1'b0;
        #1;
        check("rst_mac_out_valid", out_valid, 0);
        check("rst_mac_busy", busy, 0);
        tick();
        RST = 1'b1;
        exp_q.push_back(16'sd1);
        exp_q.push_back(16'sd10);
        exp_q.push_back(16'sd0);
        exp_q.push_back(16'sd0);
        send(1, 1'b0);
        for (int i = 0; i < 4; i++) send(0, 1'b0);
        wait_drain();

        // Random coefficients and samples against the behavioural model.
        apply_reset();
        for (int i = 0; i < TN; i++) begin
            h_m[i] = int'($urandom_range(0, 400)) - 200;
            wr_coef(i, h_m[i], 1'b0);
        end
        n_rand = 60;
        for (int i = 0; i < n_rand; i++) xs.push_back(int'($urandom_range(0, 4000)) - 2000);
        for (int m = 0; (m * MM) / LL < n_rand; m++) exp_q.push_back(DW'(model_y(m)));
        rand_rdy = 1'b1;
        for (int i = 0; i < n_rand; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            send(xs[i], 1'b0);
        end
        wait_drain();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
